// File: rtl/piton_reset_seq.sv
// Reset sequencer for the OpenPiton shell: releases the chipset once memory is
// calibrated, then the tile array unless the host holds the cores in reset.
module piton_reset_seq #(
  parameter int RST_HOLD_CYCLES    = 64,
  parameter int CHIP_DELAY_CYCLES  = 32,
  parameter int SYNC_STAGES        = 2,
  parameter int STABLE_CYCLES      = 16,
  parameter int MEM_TIMEOUT_CYCLES = 1048576
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [4:0] pcie_gpio,
  input  logic       mem_ready,
  output logic       chipset_rst_n,
  output logic       chip_rst_n,
  output logic [2:0] seq_state,
  output logic       mem_timeout,
  output logic [7:0] rst_count
);

  // state       | meaning
  // S_RST       | both resets asserted, hold timer running
  // S_WAIT_MEM  | both resets asserted, waiting for memory calibration
  // S_CHIPSET   | chipset released, chip held for the release delay
  // S_HOLD      | chipset released, chip held by host core-hold
  // S_RUN       | both resets released
  typedef enum logic [2:0] {
    S_RST      = 3'd0,
    S_WAIT_MEM = 3'd1,
    S_CHIPSET  = 3'd2,
    S_HOLD     = 3'd3,
    S_RUN      = 3'd4
  } state_t;

  localparam int HOLD_W = $clog2(RST_HOLD_CYCLES + 1);
  localparam int CHIP_W = $clog2(CHIP_DELAY_CYCLES + 1);
  localparam int TMO_W  = $clog2(MEM_TIMEOUT_CYCLES + 1);
  localparam int DEB_W  = $clog2(STABLE_CYCLES + 1);

  logic [2:0]        r_sync [SYNC_STAGES];
  logic [2:0]        w_sync;
  logic              w_mem_rdy;
  logic [1:0]        r_deb;
  logic [DEB_W-1:0]  r_deb_cnt [2];
  logic              r_deb0_d;
  logic              w_soft_req;
  logic              w_unused_gpio;

  state_t            r_state;
  state_t            w_next;
  logic              w_entry;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [CHIP_W-1:0] r_chip_cnt;
  logic [TMO_W-1:0]  r_tmo_cnt;
  logic              r_mem_timeout;
  logic [7:0]        r_rst_count;
  logic              r_chipset_rst_n;
  logic              r_chip_rst_n;

  assign w_unused_gpio = ^pcie_gpio[4:2];

  // Synchronizer chain carries {mem_ready, core_hold, soft_reset}.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= 3'b000;
    end else begin
      r_sync[0] <= {mem_ready, pcie_gpio[1:0]};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_sync    = r_sync[SYNC_STAGES-1];
  assign w_mem_rdy = w_sync[2];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_deb     <= 2'b00;
      r_deb0_d  <= 1'b0;
      for (int b = 0; b < 2; b++) r_deb_cnt[b] <= '0;
    end else begin
      r_deb0_d <= r_deb[0];
      for (int b = 0; b < 2; b++) begin
        if (w_sync[b] == r_deb[b]) begin
          r_deb_cnt[b] <= '0;
        end else if (r_deb_cnt[b] == DEB_W'(STABLE_CYCLES - 1)) begin
          r_deb[b]     <= w_sync[b];
          r_deb_cnt[b] <= '0;
        end else begin
          r_deb_cnt[b] <= r_deb_cnt[b] + 1'b1;
        end
      end
    end
  end

  assign w_soft_req = r_deb[0] & ~r_deb0_d;

  always_comb begin
    w_next = r_state;
    if (w_soft_req) begin
      w_next = S_RST;
    end else begin
      case (r_state)
        S_RST:      if (r_hold_cnt == HOLD_W'(RST_HOLD_CYCLES) && !r_deb[0]) w_next = S_WAIT_MEM;
        S_WAIT_MEM: if (w_mem_rdy) w_next = S_CHIPSET;
        S_CHIPSET: begin
          if (!w_mem_rdy) w_next = S_RST;
          else if (r_chip_cnt == CHIP_W'(CHIP_DELAY_CYCLES - 1)) w_next = r_deb[1] ? S_HOLD : S_RUN;
        end
        S_HOLD:     if (!w_mem_rdy) w_next = S_RST; else if (!r_deb[1]) w_next = S_RUN;
        S_RUN:      if (!w_mem_rdy) w_next = S_RST; else if (r_deb[1]) w_next = S_HOLD;
        default:    w_next = S_RST;
      endcase
    end
  end

  // A soft request while already in S_RST is a fresh entry and restarts the hold.
  assign w_entry = (w_next != r_state) || w_soft_req;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state         <= S_RST;
      r_hold_cnt      <= '0;
      r_chip_cnt      <= '0;
      r_tmo_cnt       <= '0;
      r_mem_timeout   <= 1'b0;
      r_rst_count     <= 8'd0;
      r_chipset_rst_n <= 1'b0;
      r_chip_rst_n    <= 1'b0;
    end else begin
      r_state         <= w_next;
      r_chipset_rst_n <= (w_next inside {S_CHIPSET, S_HOLD, S_RUN});
      r_chip_rst_n    <= (w_next == S_RUN);
      if (w_entry) begin
        r_hold_cnt <= '0;
        r_chip_cnt <= '0;
        r_tmo_cnt  <= '0;
      end else begin
        if (r_state == S_RST && r_hold_cnt != HOLD_W'(RST_HOLD_CYCLES))
          r_hold_cnt <= r_hold_cnt + 1'b1;
        if (r_state == S_CHIPSET && r_chip_cnt != CHIP_W'(CHIP_DELAY_CYCLES))
          r_chip_cnt <= r_chip_cnt + 1'b1;
        if (r_state == S_WAIT_MEM && r_tmo_cnt != TMO_W'(MEM_TIMEOUT_CYCLES))
          r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
      if (w_soft_req) begin
        r_mem_timeout <= 1'b0;
        if (r_rst_count != 8'hFF) r_rst_count <= r_rst_count + 1'b1;
      end else if (r_state == S_WAIT_MEM && r_tmo_cnt == TMO_W'(MEM_TIMEOUT_CYCLES - 1)) begin
        r_mem_timeout <= 1'b1;
      end
    end
  end

  assign chipset_rst_n = r_chipset_rst_n;
  assign chip_rst_n    = r_chip_rst_n;
  assign seq_state     = r_state;
  assign mem_timeout   = r_mem_timeout;
  assign rst_count     = r_rst_count;

endmodule

// File: doc/piton_reset_seq.md
# piton_reset_seq

Reset sequencer for the OpenPiton accelerator shell. It takes host-driven `pcie_gpio` control bits and the memory-controller `mem_ready` status and sequences two resets. The chipset (NoC bridges, memory/ethernet/SRAM/UART AXI masters) is released only after memory is ready. The tile array is released after that, and only while the host does not hold the cores in reset. Status outputs expose the sequencer state, a memory-timeout flag and a soft-reset counter for debug.

## Interface
- `RST_HOLD_CYCLES`, 64: minimum cycles both resets stay asserted in S_RST.
- `CHIP_DELAY_CYCLES`, 32: cycles between chipset release and chip release.
- `SYNC_STAGES`, 2: flop stages on `pcie_gpio` and `mem_ready`.
- `STABLE_CYCLES`, 16: cycles a synchronized gpio bit must hold a new value before the debounced value changes.
- `MEM_TIMEOUT_CYCLES`, 1048576: cycles in S_WAIT_MEM before `mem_timeout` is set.
- `sys_clk` in 1: single clock for the whole block.
- `sys_rst_n` in 1: asynchronous assert, active-low; the deassertion edge is already synchronous to `sys_clk`.
- `pcie_gpio` in 5: bit0 is the soft-reset request (level, active high); bit1 is core hold (level, active high); bits 4:2 are ignored.
- `mem_ready` in 1: memory-controller calibration done; asynchronous to `sys_clk`.
- `chipset_rst_n` out 1: active-low chipset reset.
- `chip_rst_n` out 1: active-low tile-array reset.
- `seq_state` out 3: current state encoding.
- `mem_timeout` out 1: sticky, set when memory readiness times out.
- `rst_count` out 8: number of accepted soft resets, saturating.

## Operation
- **Input conditioning**
  - `mem_ready` and `pcie_gpio[1:0]` each pass through `SYNC_STAGES` flops.
  - Bits 0 and 1 are debounced independently. The debounced value takes the new synchronized value only after `STABLE_CYCLES` consecutive equal samples. Any mismatch restarts that bit's counter.
  - `soft_req` is the rising edge of debounced bit0.
- **States** (`seq_state` encoding)
  - S_RST=0: both resets asserted. Counter runs `RST_HOLD_CYCLES`. Exits to S_WAIT_MEM on expiry only if debounced bit0 is 0; otherwise the counter stays saturated and the block waits.
  - S_WAIT_MEM=1: both resets asserted. Exits to S_CHIPSET when synchronized `mem_ready`=1. A timeout counter sets `mem_timeout` after `MEM_TIMEOUT_CYCLES`; the block keeps waiting.
  - S_CHIPSET=2: `chipset_rst_n`=1, chip held in reset. Counter runs `CHIP_DELAY_CYCLES`. On expiry, goes to S_RUN if core hold is 0, else S_HOLD.
  - S_HOLD=3: chipset released, chip held. Goes to S_RUN when debounced core hold falls.
  - S_RUN=4: both resets released. Goes to S_HOLD when core hold rises.
  - Codes 5-7 are unreachable and recover to S_RST.
- **Global transitions**, by priority from any state:
  1. `soft_req` goes to S_RST, increments `rst_count` (saturating at 255) and clears `mem_timeout`.
  2. Synchronized `mem_ready`=0 in S_CHIPSET, S_HOLD or S_RUN goes to S_RST and does not increment `rst_count`.
  3. Core-hold transitions as listed above.
- **Counters**
  - Each counter is sized `$clog2(param+1)`.
  - Counters clear on every state entry.
- **Output decode**
  - Outputs are registered and decoded from the next state, so each output changes on the same edge the state changes.
  - `chipset_rst_n` = (state ∈ {2,3,4}).
  - `chip_rst_n` = (state == 4).

## Timing
- **Reset values:** `chipset_rst_n`=0, `chip_rst_n`=0, `seq_state`=0, `mem_timeout`=0, `rst_count`=0. All synchronizer and debounce flops reset to 0.
- **Cold boot** (cycle 0 = first edge with `sys_rst_n` high; gpio=0; `mem_ready`=1 steady):
  - S_WAIT_MEM is entered at edge `RST_HOLD_CYCLES`.
  - `chipset_rst_n` rises at edge `RST_HOLD_CYCLES`+1.
  - `chip_rst_n` rises at edge `RST_HOLD_CYCLES`+1+`CHIP_DELAY_CYCLES`.
  - With defaults these are cycles 65 and 97.
- **Soft reset:** a bit0 0→1 transition held steady asserts both resets `SYNC_STAGES`+`STABLE_CYCLES`+1 edges after the first sampling edge (19 with defaults).
- **Core hold:** a bit1 rise drops `chip_rst_n` after the same latency. `chipset_rst_n` is unaffected.
- **mem_ready loss:** both resets assert `SYNC_STAGES`+1 edges after `mem_ready` falls.
- **Simultaneous events:** `soft_req` and `mem_ready` loss in the same cycle → one S_RST entry, counted as a soft reset.
- **`sys_rst_n` mid-sequence:** all outputs return to reset values immediately (asynchronously).
- **Glitches:** a gpio pulse shorter than `STABLE_CYCLES` produces no effect.

## Test plan
- **Cold boot:** defaults, `mem_ready`=1, gpio=0 → `chipset_rst_n` rises at cycle 65, `chip_rst_n` at cycle 97; `seq_state` goes 0→1→2→4.
- **Memory late:** `mem_ready` held 0 with `MEM_TIMEOUT_CYCLES`=100 → `mem_timeout`=1 at cycle 64+100, resets stay asserted. Then `mem_ready`=1 → boot completes. Then soft reset → `mem_timeout`=0 and `rst_count`=1.
- **Soft reset in S_RUN:** bit0 held high for 40 cycles → both resets low after 19 cycles, held until bit0 has been debounced low, then full resequence; `rst_count` increments by 1.
- **Debounce:** a 10-cycle pulse on bit0, then a 10-cycle pulse on bit1, in S_RUN → no output change, `rst_count` unchanged.
- **Core hold:** bit1=1 during S_CHIPSET → S_HOLD at expiry with `chip_rst_n`=0. bit1=0 → S_RUN 19 cycles later. Drop `mem_ready` in S_RUN → S_RST after 3 edges, `rst_count` unchanged.
- **Async reset:** pulse `sys_rst_n` low mid-S_CHIPSET → all outputs go to reset values without a clock edge, and the cold-boot timing repeats.
